step_scheduler: RTL and testbench
=================================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 12_500_000, clk cycles per step at speed level 0.
REQ-002 SHALL have parameter PERIOD_STEP, default 1_250_000, cycles removed per speed level; 7*PERIOD_STEP < BASE_PERIOD.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-004 SHALL have port run  in  1  game in play, from the top-level game FSM.
REQ-005 SHALL have port score  in  8  current score.
REQ-006 SHALL have port dir_req  in  2  requested direction: 0 up, 1 down, 2 left, 3 right.
REQ-007 SHALL have ports shift_req  out  1 and shift_ack  in  1, the body-shift handshake.
REQ-008 SHALL have ports hit_wall, hit_self, ate_food  in  1 each, collision and food flags.
REQ-009 SHALL have ports food_req  out  1 and food_ack  in  1, the food-generator handshake.
REQ-010 SHALL have outputs dead_pulse  1, grow  1, dir_cur  2, state_out  3.

Function
REQ-011 SHALL implement states IDLE=0, WAIT=1, LATCH=2, SHIFT=3, CHECK=4, FOOD=5, DEAD=6; state_out SHALL equal the state code.
REQ-012 IDLE: run=1 -> WAIT; otherwise stay.
REQ-013 WAIT: run=0 -> IDLE (counter cleared); tick -> LATCH.
REQ-014 Tick counter SHALL run only in WAIT, clear on WAIT entry, and fire when count == period-1.
REQ-015 Speed: level = min(score>>2, 7); period = BASE_PERIOD - level*PERIOD_STEP; score SHALL be sampled on each WAIT entry.
REQ-016 LATCH: dir_cur <= dir_req unless reversal (dir_req[1]==dir_cur[1] and dir_req[0]!=dir_cur[0]); reversal keeps dir_cur; -> SHIFT.
REQ-017 SHIFT: shift_req=1 (Moore); on shift_ack -> CHECK; shift_ack outside SHIFT SHALL be ignored.
REQ-018 CHECK: hit_wall|hit_self -> DEAD with dead_pulse=1 for exactly one cycle; else ate_food -> FOOD with grow=1 for one cycle; else -> WAIT.
REQ-019 Collision SHALL take priority over ate_food in the same CHECK cycle: no grow, no food_req.
REQ-020 FOOD: food_req=1 (Moore) until food_ack -> WAIT; food_ack outside FOOD SHALL be ignored.
REQ-021 SHIFT and FOOD SHALL NOT abort on run=0; the step completes, and WAIT then returns to IDLE.
REQ-022 DEAD: hold until run=0 -> IDLE.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, counter 0, dir_cur=3 (right), and shift_req, food_req, dead_pulse, grow all 0, including mid-handshake.

Structure
REQ-024 State codes and direction codes SHALL live in shared package snake_pkg.
REQ-025 The period counter and speed calculation SHALL be sub-module step_tick_gen (inputs clk, rst_n, clear, score; output tick).
REQ-026 All registers SHALL be in the clk domain; there SHALL be no combinational path from any *_ack to any *_req.

Verification (BASE_PERIOD=16, PERIOD_STEP=2)
REQ-027 rst_n release, run=1, score=0 -> state WAIT 16 cycles, LATCH 1, then shift_req high 18 edges after run is first sampled.
REQ-028 score=40 -> level capped at 7, period 2 -> LATCH two cycles after WAIT entry.
REQ-029 dir_cur=3, dir_req=2 -> dir_cur stays 3; next step dir_req=0 -> dir_cur=0.
REQ-030 CHECK with hit_self=1 and ate_food=1 -> DEAD, dead_pulse one cycle, food_req never high; run=0 -> IDLE.
REQ-031 ate_food=1, food_ack 5 cycles later -> grow one cycle, food_req high 5 cycles, then WAIT.
REQ-032 rst_n low while in SHIFT with shift_ack=0 -> shift_req 0 without waiting for a clk edge, state_out=0, dir_cur=3.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// snake_pkg : state/direction codes and speed helpers for the snake stepper
// Rev 1.0
// ============================================================================
package snake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_CHECK = 3'd4,
        ST_FOOD  = 3'd5,
        ST_DEAD  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [2:0] MAX_LEVEL = 3'd7;

    // One speed level per four points, saturating at the fastest level.
    function automatic logic [2:0] speed_level(input logic [7:0] score);
        logic [7:0] quarter;
        quarter = score >> 2;
        return (quarter > {5'd0, MAX_LEVEL}) ? MAX_LEVEL : quarter[2:0];
    endfunction

    // Opposite directions share bit 1 and differ in bit 0.
    function automatic logic is_reversal(input logic [1:0] req, input logic [1:0] cur);
        return (req[1] == cur[1]) && (req[0] != cur[0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// ============================================================================
// step_tick_gen : score-dependent step period counter, held clear outside WAIT
// Rev 1.0
// ============================================================================
module step_tick_gen
    import snake_pkg::*;
#(
    parameter int BASE_PERIOD = 12_500_000,
    parameter int PERIOD_STEP = 1_250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] score,
    output logic       tick
);

    localparam int            CNT_W     = $clog2(BASE_PERIOD + 1);
    localparam logic [CNT_W-1:0] BASE_LAST = CNT_W'(BASE_PERIOD - 1);
    localparam logic [CNT_W-1:0] STEP_CYC  = CNT_W'(PERIOD_STEP);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] w_level;

    // The terminal count is reloaded every cycle while cleared, so the value
    // held on entry to counting reflects the score at that entry edge.
    always_comb begin
        w_level = CNT_W'(speed_level(score));
        last_d  = clear ? (BASE_LAST - w_level * STEP_CYC) : last_q;
        count_d = (clear || tick) ? '0 : count_q + CNT_W'(1);
    end

    assign tick = !clear && (count_q == last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            last_q  <= BASE_LAST;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/step_scheduler.sv
`default_nettype none
// ============================================================================
// step_scheduler : per-step sequencing of the snake (wait, turn, shift, check)
// Rev 1.0
// ============================================================================
module step_scheduler
    import snake_pkg::*;
#(
    parameter int BASE_PERIOD = 12_500_000,
    parameter int PERIOD_STEP = 1_250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] score,
    input  logic [1:0] dir_req,
    output logic       shift_req,
    input  logic       shift_ack,
    input  logic       hit_wall,
    input  logic       hit_self,
    input  logic       ate_food,
    output logic       food_req,
    input  logic       food_ack,
    output logic       dead_pulse,
    output logic       grow,
    output logic [1:0] dir_cur,
    output logic [2:0] state_out
);

    state_t state_q, state_d;
    dir_t   dir_q, dir_d;
    logic   dead_q, dead_d;
    logic   grow_q, grow_d;
    logic   w_tick;
    logic   w_clear;

    assign w_clear = (state_q != ST_WAIT);

    step_tick_gen #(
        .BASE_PERIOD (BASE_PERIOD),
        .PERIOD_STEP (PERIOD_STEP)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .score (score),
        .tick  (w_tick)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dead_d  = 1'b0;
        grow_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!run)        state_d = ST_IDLE;
                else if (w_tick) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (!is_reversal(dir_req, dir_q)) dir_d = dir_t'(dir_req);
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_ack) state_d = ST_CHECK;
            end
            // A collision outranks food eaten on the same step.
            ST_CHECK: begin
                if (hit_wall || hit_self) begin
                    state_d = ST_DEAD;
                    dead_d  = 1'b1;
                end else if (ate_food) begin
                    state_d = ST_FOOD;
                    grow_d  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FOOD: begin
                if (food_ack) state_d = ST_WAIT;
            end
            ST_DEAD: begin
                if (!run) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RIGHT;
            dead_q  <= 1'b0;
            grow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            grow_q  <= grow_d;
        end
    end

    // Requests decode the state register only, keeping acks off the req paths.
    assign shift_req  = (state_q == ST_SHIFT);
    assign food_req   = (state_q == ST_FOOD);
    assign dead_pulse = dead_q;
    assign grow       = grow_q;
    assign dir_cur    = dir_q;
    assign state_out  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_step_scheduler.sv
`default_nettype none
// ============================================================================
// tb_step_scheduler : randomized step sequences against a step-level model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_step_scheduler;

    localparam int BASE = 16;
    localparam int STEP = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       run       = 1'b0;
    logic [7:0] score     = 8'd0;
    logic [1:0] dir_req   = 2'd0;
    logic       shift_ack = 1'b0;
    logic       hit_wall  = 1'b0;
    logic       hit_self  = 1'b0;
    logic       ate_food  = 1'b0;
    logic       food_ack  = 1'b0;
    logic       shift_req, food_req, dead_pulse, grow;
    logic [1:0] dir_cur;
    logic [2:0] state_out;

    int n_cmp     = 0;
    int n_bad     = 0;
    int cyc       = 0;
    int model_dir = 3;
    int cur_score = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_scheduler #(
        .BASE_PERIOD (BASE),
        .PERIOD_STEP (STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .score      (score),
        .dir_req    (dir_req),
        .shift_req  (shift_req),
        .shift_ack  (shift_ack),
        .hit_wall   (hit_wall),
        .hit_self   (hit_self),
        .ate_food   (ate_food),
        .food_req   (food_req),
        .food_ack   (food_ack),
        .dead_pulse (dead_pulse),
        .grow       (grow),
        .dir_cur    (dir_cur),
        .state_out  (state_out)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_period(input int sc);
        int lvl;
        lvl = sc / 4;
        if (lvl > 7) lvl = 7;
        return BASE - lvl * STEP;
    endfunction

    function automatic int exp_dir(input int cur, input int req);
        if (req != cur && (req / 2) == (cur / 2)) return cur;
        return req;
    endfunction

    // Entered with the DUT observed in its first WAIT cycle; returns the same way.
    // outcome: 0 none, 1 food, 2 wall, 3 self, 4 self+food, 5 wall+food
    task automatic do_step(input int sc_next, input int dr, input int outcome,
                           input int sdly, input int fdly, input bit drop_run,
                           output int shift_cyc);
        int  wlen, fr, gr, entry;
        bit  drop_now;
        entry = cur_score;
        wlen  = 1;
        dir_req = dr[1:0];
        while (state_out == 3'd1 && wlen < 64) begin
            shift_ack = 1'($urandom_range(0, 1));
            food_ack  = 1'($urandom_range(0, 1));
            hit_wall  = 1'($urandom_range(0, 1));
            ate_food  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (state_out == 3'd1) wlen++;
        end
        shift_ack = 0; food_ack = 0; hit_wall = 0; hit_self = 0; ate_food = 0;
        check("wait_len", wlen, exp_period(entry));
        check("latch_state", state_out, 2);
        @(negedge clk);
        shift_cyc = cyc;
        model_dir = exp_dir(model_dir, dr);
        check("shift_state", state_out, 3);
        check("shift_req", shift_req, 1);
        check("dir_cur", dir_cur, model_dir);
        score = sc_next[7:0];
        cur_score = sc_next;
        drop_now = drop_run && (outcome < 2);
        if (drop_now) run = 0;
        for (int k = 0; k < sdly; k++) begin
            food_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("shift_hold", shift_req, 1);
        end
        food_ack = 0;
        shift_ack = 1;
        @(negedge clk);
        shift_ack = 0;
        check("check_state", state_out, 4);
        check("shift_drop", shift_req, 0);
        hit_wall = (outcome == 2 || outcome == 5);
        hit_self = (outcome == 3 || outcome == 4);
        ate_food = (outcome == 1 || outcome >= 4);
        @(negedge clk);
        hit_wall = 0; hit_self = 0; ate_food = 0;
        if (outcome >= 2) begin
            check("dead_state", state_out, 6);
            check("dead_pulse", dead_pulse, 1);
            check("dead_no_grow", grow, 0);
            check("dead_no_food", food_req, 0);
            @(negedge clk);
            check("dead_pulse_end", dead_pulse, 0);
            check("dead_hold", state_out, 6);
            check("dead_no_food2", food_req, 0);
            run = 0;
            @(negedge clk);
            check("dead_to_idle", state_out, 0);
            run = 1;
            @(negedge clk);
            check("rerun_wait", state_out, 1);
        end else begin
            if (outcome == 1) begin
                check("food_state", state_out, 5);
                fr = int'(food_req);
                gr = int'(grow);
                for (int k = 1; k < fdly; k++) begin
                    @(negedge clk);
                    fr += int'(food_req);
                    gr += int'(grow);
                end
                food_ack = 1;
                @(negedge clk);
                food_ack = 0;
                check("food_req_len", fr, fdly);
                check("grow_count", gr, 1);
                check("food_drop", food_req, 0);
            end
            check("back_to_wait", state_out, 1);
            if (drop_now) begin
                @(negedge clk);
                check("wait_to_idle", state_out, 0);
                run = 1;
                @(negedge clk);
                check("idle_to_wait", state_out, 1);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, sc, o, outcome, guard;
        repeat (3) @(negedge clk);
        check("rst_state", state_out, 0);
        check("rst_dir", dir_cur, 3);
        check("rst_shift_req", shift_req, 0);
        check("rst_food_req", food_req, 0);
        check("rst_dead", dead_pulse, 0);
        check("rst_grow", grow, 0);
        rst_n = 1;
        @(negedge clk);
        check("idle_no_run", state_out, 0);

        score = 0; cur_score = 0; run = 1; t0 = cyc;
        @(negedge clk);
        check("wait_entry", state_out, 1);
        do_step(40, 2, 0, 0, 1, 0, sc);          // left while heading right is refused
        check("first_shift_edges", sc - t0, 18);
        do_step(3, 0, 1, 2, 5, 0, sc);           // fast period at score 40, turn up, grow
        do_step(9, 1, 4, 1, 1, 0, sc);           // down while up is refused; self hit + food
        do_step(12, 2, 5, 0, 1, 0, sc);

        for (int i = 0; i < 25; i++) begin
            o = $urandom_range(0, 8);
            outcome = (o < 3) ? 0 : (o < 5) ? 1 : o - 3;
            do_step($urandom_range(0, 255), $urandom_range(0, 3), outcome,
                    $urandom_range(0, 3), $urandom_range(1, 6),
                    ($urandom_range(0, 3) == 0), sc);
        end

        dir_req = (model_dir == 1) ? 2'd2 : 2'd0;
        model_dir = exp_dir(model_dir, int'(dir_req));
        guard = 0;
        while (state_out != 3'd3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reach_shift", state_out, 3);
        check("pre_rst_dir", dir_cur, model_dir);
        rst_n = 0;
        #1;
        check("async_rst_shift_req", shift_req, 0);
        check("async_rst_state", state_out, 0);
        check("async_rst_dir", dir_cur, 3);
        check("async_rst_food_req", food_req, 0);
        @(negedge clk);
        check("rst_held_state", state_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
